// File: rtl/spi_cmd_rx.sv
// SPI mode-0 command receiver: syncs sck/sdi/cs into clk, assembles MSB-first frames,
// queues good frames in an FWFT FIFO (valid/ready, drop + sticky overflow when full).
module spi_cmd_rx #(
   parameter int BYTES       = 2,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH     = 31
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     sck_i,
   input  logic                     sdi_i,
   input  logic                     cs_i,
   output logic [8*BYTES-1:0]       frame_data_o,
   output logic                     frame_valid_o,
   input  logic                     frame_ready_i,
   output logic                     frame_error_o,
   output logic                     overflow_o,
   output logic [$clog2(DEPTH):0]   fifo_count_o,
   output logic                     activity_o
);

   localparam int FW = 8 * BYTES;
   localparam int CW = $clog2(FW + 2);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STRETCH + 1);

   localparam logic [CW-1:0] CNT_FULL = CW'(FW);
   localparam logic [CW-1:0] CNT_MAX  = CW'(FW + 1);
   localparam logic [AW:0]   FIFO_CAP = (AW + 1)'(DEPTH);
   localparam logic [SW-1:0] ACT_LOAD = SW'(STRETCH);

   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] sdi_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic                   sck_prev_q;
   logic                   cs_prev_q;

   logic sck_s, sdi_s, cs_s;
   logic sck_rise, cs_fall, cs_rise;

   logic [FW-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]   bitcnt_q, bitcnt_d;
   logic            frame_error_q;

   logic [FW-1:0]   mem_q [DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic            overflow_q, overflow_d;
   logic [SW-1:0]   act_q, act_d;

   logic [AW:0]     count;
   logic            fifo_full, fifo_empty;
   logic            frame_good, frame_bad;
   logic            pop, push_ok;

   // cs idles high, so its synchroniser resets to 1 to avoid a false frame start.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sck_sync_q <= '0;
         sdi_sync_q <= '0;
         cs_sync_q  <= '1;
         sck_prev_q <= 1'b0;
         cs_prev_q  <= 1'b1;
      end else begin
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
         sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
         cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
         sck_prev_q <= sck_s;
         cs_prev_q  <= cs_s;
      end
   end

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign cs_fall  = ~cs_s & cs_prev_q;
   assign cs_rise  = cs_s & ~cs_prev_q;

   always_comb begin
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      if (cs_fall) begin
         shreg_d  = '0;
         bitcnt_d = '0;
      end else if (sck_rise && !cs_s) begin
         shreg_d = {shreg_q[FW-2:0], sdi_s};
         // Saturate one past full so long frames stay distinguishable from good ones.
         if (bitcnt_q != CNT_MAX) begin
            bitcnt_d = bitcnt_q + CW'(1);
         end
      end
   end

   assign frame_good = cs_rise && (bitcnt_q == CNT_FULL);
   assign frame_bad  = cs_rise && (bitcnt_q != CNT_FULL);

   assign count      = wr_ptr_q - rd_ptr_q;
   assign fifo_full  = (count == FIFO_CAP);
   assign fifo_empty = (count == '0);
   assign pop        = ~fifo_empty & frame_ready_i;
   // A pop in the same cycle frees the slot the full-FIFO push lands in.
   assign push_ok    = frame_good & (~fifo_full | pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      act_d      = act_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
      end
      if (frame_good && !push_ok) begin
         overflow_d = 1'b1;
      end
      if (push_ok) begin
         act_d = ACT_LOAD;
      end else if (act_q != '0) begin
         act_d = act_q - SW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         shreg_q       <= '0;
         bitcnt_q      <= '0;
         frame_error_q <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         overflow_q    <= 1'b0;
         act_q         <= '0;
      end else begin
         shreg_q       <= shreg_d;
         bitcnt_q      <= bitcnt_d;
         frame_error_q <= frame_bad;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         overflow_q    <= overflow_d;
         act_q         <= act_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
      end
   end

   // Storage is not reset; gating with empty keeps the head at zero after reset.
   assign frame_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign frame_valid_o = ~fifo_empty;
   assign frame_error_o = frame_error_q;
   assign overflow_o    = overflow_q;
   assign fifo_count_o  = count;
   assign activity_o    = (act_q != '0);

endmodule
